// File: rtl/hazard_controller.sv
// hazard_controller: pipeline forwarding/stall/flush control plus a mult/div busy tracker.
module hazard_controller #(
    parameter int MUL_CYCLES = 4,
    parameter int DIV_CYCLES = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  RsD,
    input  logic [4:0]  RtD,
    input  logic [4:0]  RsE,
    input  logic [4:0]  RtE,
    input  logic [4:0]  WriteRegE,
    input  logic [4:0]  WriteRegM,
    input  logic [4:0]  WriteRegW,
    input  logic        RegWriteE,
    input  logic        RegWriteM,
    input  logic        RegWriteW,
    input  logic        MemToRegE,
    input  logic        MemToRegM,
    input  logic        BranchD,
    input  logic        PCSrcD,
    input  logic        HiLoAccessD,
    input  logic        MdStartE,
    input  logic        MdOpE,
    output logic        StallF,
    output logic        StallD,
    output logic        FlushD,
    output logic        FlushE,
    output logic [1:0]  ForwardAD,
    output logic [1:0]  ForwardBD,
    output logic [1:0]  ForwardAE,
    output logic [1:0]  ForwardBE,
    output logic        MdBusy,
    output logic        MdDone,
    output logic        MdOverlapErr,
    output logic [15:0] StallCount
);
    localparam logic [7:0] MUL_LOAD = 8'(MUL_CYCLES - 1);
    localparam logic [7:0] DIV_LOAD = 8'(DIV_CYCLES - 1);

    typedef enum logic {RUN, MDWAIT} state_t;

    state_t     state, state_next;
    logic [7:0] cnt, cnt_next;
    logic       lwstall, branchstall, mdstall, stall;

    // Register 0 is hardwired, so it never creates a dependency.
    function automatic logic hit(input logic [4:0] a, input logic [4:0] b);
        return (a != 5'd0) && (a == b);
    endfunction

    function automatic logic [1:0] fwd(input logic [4:0] r);
        return (RegWriteM && hit(r, WriteRegM)) ? 2'b01 :
               (RegWriteW && hit(r, WriteRegW)) ? 2'b10 : 2'b00;
    endfunction

    always_comb begin
        ForwardAD   = fwd(RsD);
        ForwardBD   = fwd(RtD);
        ForwardAE   = fwd(RsE);
        ForwardBE   = fwd(RtE);
        lwstall     = MemToRegE & RegWriteE & (hit(RsD, WriteRegE) | hit(RtD, WriteRegE));
        branchstall = BranchD & ((RegWriteE & (hit(RsD, WriteRegE) | hit(RtD, WriteRegE))) |
                                 (MemToRegM & (hit(RsD, WriteRegM) | hit(RtD, WriteRegM))));
        mdstall     = HiLoAccessD & (MdBusy | MdStartE);
        stall       = lwstall | branchstall | mdstall;
        StallF      = stall;
        StallD      = stall;
        FlushE      = stall;
        FlushD      = PCSrcD & ~stall;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= RUN;
            cnt          <= 8'd0;
            MdOverlapErr <= 1'b0;
            StallCount   <= 16'd0;
        end else begin
            state        <= state_next;
            cnt          <= cnt_next;
            MdOverlapErr <= MdOverlapErr | (MdStartE & (state == MDWAIT));
            if (StallD && StallCount != 16'hFFFF)
                StallCount <= StallCount + 16'd1;
        end
    end

    // A start seen while waiting (including the done cycle) is dropped.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        if (state == RUN) begin
            if (MdStartE) begin
                state_next = MDWAIT;
                cnt_next   = MdOpE ? DIV_LOAD : MUL_LOAD;
            end
        end else if (cnt == 8'd0) begin
            state_next = RUN;
        end else begin
            cnt_next = cnt - 8'd1;
        end
    end

    always_comb begin
        MdBusy = (state == MDWAIT);
        MdDone = (state == MDWAIT) && (cnt == 8'd0);
    end
endmodule

// File: tb/tb_hazard_controller.sv
// tb_hazard_controller: directed self-checking bench for hazard_controller.
module tb_hazard_controller;
    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  RsD, RtD, RsE, RtE, WriteRegE, WriteRegM, WriteRegW;
    logic        RegWriteE, RegWriteM, RegWriteW, MemToRegE, MemToRegM;
    logic        BranchD, PCSrcD, HiLoAccessD, MdStartE, MdOpE;
    logic        StallF, StallD, FlushD, FlushE;
    logic [1:0]  ForwardAD, ForwardBD, ForwardAE, ForwardBE;
    logic        MdBusy, MdDone, MdOverlapErr;
    logic [15:0] StallCount;

    int tests = 0;
    int fails = 0;
    logic [15:0] exp_sc = 16'd0;

    hazard_controller dut (
        .clk(clk), .rst(rst),
        .RsD(RsD), .RtD(RtD), .RsE(RsE), .RtE(RtE),
        .WriteRegE(WriteRegE), .WriteRegM(WriteRegM), .WriteRegW(WriteRegW),
        .RegWriteE(RegWriteE), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
        .MemToRegE(MemToRegE), .MemToRegM(MemToRegM),
        .BranchD(BranchD), .PCSrcD(PCSrcD), .HiLoAccessD(HiLoAccessD),
        .MdStartE(MdStartE), .MdOpE(MdOpE),
        .StallF(StallF), .StallD(StallD), .FlushD(FlushD), .FlushE(FlushE),
        .ForwardAD(ForwardAD), .ForwardBD(ForwardBD),
        .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
        .MdBusy(MdBusy), .MdDone(MdDone), .MdOverlapErr(MdOverlapErr),
        .StallCount(StallCount)
    );

    always #5 clk = ~clk;

    task automatic clear_inputs();
        RsD = 0; RtD = 0; RsE = 0; RtE = 0;
        WriteRegE = 0; WriteRegM = 0; WriteRegW = 0;
        RegWriteE = 0; RegWriteM = 0; RegWriteW = 0;
        MemToRegE = 0; MemToRegM = 0;
        BranchD = 0; PCSrcD = 0; HiLoAccessD = 0; MdStartE = 0; MdOpE = 0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        clear_inputs();
        repeat (2) @(negedge clk);
        #1;
        tests++;
        if ({MdBusy, MdDone, MdOverlapErr} !== 3'b000) begin
            fails++; $display("FAIL reset_md: got %b want 000", {MdBusy, MdDone, MdOverlapErr});
        end
        tests++;
        if (StallCount !== 16'd0) begin
            fails++; $display("FAIL reset_sc: got %0d want 0", StallCount);
        end
        tests++;
        if ({StallF, StallD, FlushD, FlushE, ForwardAD, ForwardBD, ForwardAE, ForwardBE} !== 12'd0) begin
            fails++; $display("FAIL reset_comb: got %h want 000",
                {StallF, StallD, FlushD, FlushE, ForwardAD, ForwardBD, ForwardAE, ForwardBE});
        end
        @(negedge clk);
        rst = 1'b1;
        exp_sc = 16'd0;
        @(negedge clk);
        #1;
        tests++;
        if (MdBusy !== 1'b0 || StallCount !== 16'd0) begin
            fails++; $display("FAIL reset_release: got busy=%b sc=%0d want 0 0", MdBusy, StallCount);
        end
    endtask

    task automatic test_forward();
        @(negedge clk);
        clear_inputs();
        RsE = 5; WriteRegM = 5; WriteRegW = 5; RegWriteM = 1; RegWriteW = 1;
        #1; tests++;
        if (ForwardAE !== 2'b01) begin fails++; $display("FAIL fwd_ae_prio: got %b want 01", ForwardAE); end
        RsE = 0;
        #1; tests++;
        if (ForwardAE !== 2'b00) begin fails++; $display("FAIL fwd_ae_r0: got %b want 00", ForwardAE); end
        RsE = 5; RegWriteM = 0;
        #1; tests++;
        if (ForwardAE !== 2'b10) begin fails++; $display("FAIL fwd_ae_w: got %b want 10", ForwardAE); end
        RtE = 7; WriteRegW = 7;
        #1; tests++;
        if (ForwardBE !== 2'b10 || ForwardAE !== 2'b00) begin
            fails++; $display("FAIL fwd_be_w: got be=%b ae=%b want 10 00", ForwardBE, ForwardAE);
        end
        clear_inputs();
        RsD = 9; WriteRegM = 9; RegWriteM = 1; RtD = 4; WriteRegW = 4; RegWriteW = 1;
        #1; tests++;
        if (ForwardAD !== 2'b01 || ForwardBD !== 2'b10) begin
            fails++; $display("FAIL fwd_d: got ad=%b bd=%b want 01 10", ForwardAD, ForwardBD);
        end
        RegWriteM = 0; RegWriteW = 0;
        #1; tests++;
        if (ForwardAD !== 2'b00 || ForwardBD !== 2'b00) begin
            fails++; $display("FAIL fwd_d_nowrite: got ad=%b bd=%b want 00 00", ForwardAD, ForwardBD);
        end
        tests++;
        if (StallD !== 1'b0) begin fails++; $display("FAIL fwd_nostall: got %b want 0", StallD); end
        clear_inputs();
    endtask

    task automatic test_load_use();
        @(negedge clk);
        clear_inputs();
        MemToRegE = 1; RegWriteE = 1; WriteRegE = 8; RsD = 8;
        #1; tests++;
        if ({StallF, StallD, FlushE, FlushD} !== 4'b1110) begin
            fails++; $display("FAIL lw_stall: got %b want 1110", {StallF, StallD, FlushE, FlushD});
        end
        exp_sc++;
        @(posedge clk); #1; tests++;
        if (StallCount !== exp_sc) begin fails++; $display("FAIL lw_count: got %0d want %0d", StallCount, exp_sc); end
        @(negedge clk);
        RsD = 9; RtD = 8; WriteRegE = 8;
        #1; tests++;
        if (StallD !== 1'b1) begin fails++; $display("FAIL lw_rt: got %b want 1", StallD); end
        exp_sc++;
        @(negedge clk);
        RtD = 0; WriteRegE = 0; RsD = 0;
        #1; tests++;
        if (StallD !== 1'b0) begin fails++; $display("FAIL lw_r0: got %b want 0", StallD); end
        MemToRegE = 0; WriteRegE = 8; RsD = 8;
        #1; tests++;
        if (StallD !== 1'b0) begin fails++; $display("FAIL lw_notload: got %b want 0", StallD); end
        clear_inputs();
        @(negedge clk); #1; tests++;
        if (StallCount !== exp_sc) begin fails++; $display("FAIL lw_count2: got %0d want %0d", StallCount, exp_sc); end
    endtask

    task automatic test_branch();
        @(negedge clk);
        clear_inputs();
        BranchD = 1; RtD = 3; RegWriteE = 1; WriteRegE = 3; PCSrcD = 1;
        #1; tests++;
        if ({StallD, FlushD, FlushE} !== 3'b101) begin
            fails++; $display("FAIL br_stall: got %b want 101", {StallD, FlushD, FlushE});
        end
        exp_sc++;
        @(negedge clk);
        RegWriteE = 0; MemToRegM = 1; WriteRegM = 3; WriteRegE = 0;
        #1; tests++;
        if (StallD !== 1'b1) begin fails++; $display("FAIL br_loadm: got %b want 1", StallD); end
        exp_sc++;
        @(negedge clk);
        MemToRegM = 0;
        #1; tests++;
        if ({StallD, FlushD} !== 2'b01) begin fails++; $display("FAIL br_taken: got %b want 01", {StallD, FlushD}); end
        BranchD = 0; RegWriteE = 1; WriteRegE = 3;
        #1; tests++;
        if (StallD !== 1'b0) begin fails++; $display("FAIL br_nobranch: got %b want 0", StallD); end
        clear_inputs();
        @(negedge clk); #1; tests++;
        if (StallCount !== exp_sc) begin fails++; $display("FAIL br_count: got %0d want %0d", StallCount, exp_sc); end
    endtask

    task automatic test_divide();
        @(negedge clk);
        clear_inputs();
        MdStartE = 1; MdOpE = 1; HiLoAccessD = 1;
        #1; tests++;
        if (StallD !== 1'b1 || MdBusy !== 1'b0) begin
            fails++; $display("FAIL div_start: got stall=%b busy=%b want 1 0", StallD, MdBusy);
        end
        exp_sc++;
        for (int i = 1; i <= 32; i++) begin
            @(negedge clk);
            MdStartE = 0;
            HiLoAccessD = (i == 10);
            #1; tests++;
            if (MdBusy !== 1'b1 || MdDone !== (i == 32)) begin
                fails++; $display("FAIL div_cycle%0d: got busy=%b done=%b want 1 %b", i, MdBusy, MdDone, i == 32);
            end
            if (i == 10) begin
                tests++;
                if (StallD !== 1'b1) begin fails++; $display("FAIL div_hilo: got %b want 1", StallD); end
                exp_sc++;
            end
        end
        @(negedge clk);
        clear_inputs();
        #1; tests++;
        if (MdBusy !== 1'b0 || MdDone !== 1'b0) begin
            fails++; $display("FAIL div_end: got busy=%b done=%b want 0 0", MdBusy, MdDone);
        end
        tests++;
        if (StallCount !== exp_sc) begin fails++; $display("FAIL div_count: got %0d want %0d", StallCount, exp_sc); end
    endtask

    task automatic test_overlap();
        @(negedge clk);
        clear_inputs();
        MdStartE = 1;
        for (int i = 1; i <= 5; i++) begin
            @(negedge clk);
            MdStartE = (i == 2);
            MdOpE = (i == 2);
            #1; tests++;
            if (MdBusy !== (i <= 4) || MdDone !== (i == 4) || MdOverlapErr !== (i >= 3)) begin
                fails++; $display("FAIL ovl_cycle%0d: got busy=%b done=%b err=%b want %b %b %b",
                    i, MdBusy, MdDone, MdOverlapErr, i <= 4, i == 4, i >= 3);
            end
        end
        clear_inputs();
        MdStartE = 1;
        for (int i = 1; i <= 5; i++) begin
            @(negedge clk);
            MdStartE = (i == 4);
            #1; tests++;
            if (MdBusy !== (i <= 4) || MdDone !== (i == 4) || MdOverlapErr !== 1'b1) begin
                fails++; $display("FAIL done_start%0d: got busy=%b done=%b err=%b want %b %b 1",
                    i, MdBusy, MdDone, MdOverlapErr, i <= 4, i == 4);
            end
        end
        clear_inputs();
    endtask

    task automatic test_reset_abort();
        @(negedge clk);
        clear_inputs();
        MdStartE = 1; MdOpE = 1;
        @(negedge clk);
        clear_inputs();
        @(negedge clk);
        #1; tests++;
        if (MdBusy !== 1'b1) begin fails++; $display("FAIL abort_busy: got %b want 1", MdBusy); end
        rst = 1'b0;
        #1; tests++;
        if (MdBusy !== 1'b0 || MdOverlapErr !== 1'b0 || StallCount !== 16'd0) begin
            fails++; $display("FAIL abort_async: got busy=%b err=%b sc=%0d want 0 0 0", MdBusy, MdOverlapErr, StallCount);
        end
        exp_sc = 16'd0;
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            #1; tests++;
            if (MdDone !== 1'b0 || MdBusy !== 1'b0) begin
                fails++; $display("FAIL abort_after%0d: got done=%b busy=%b want 0 0", i, MdDone, MdBusy);
            end
        end
    endtask

    initial begin
        test_reset();
        test_forward();
        test_load_use();
        test_branch();
        test_divide();
        test_overlap();
        test_reset_abort();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
